// File: rtl/ansi_parser.sv
// rtl/ansi_parser.sv - VT100/ANSI escape parser splitting a byte stream into characters and commands
module ansi_parser #(
    parameter int TIMEOUT_CLKS = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_v,
    output logic [7:0] o_char,
    output logic       o_char_v,
    output logic [3:0] o_cmd,
    output logic [7:0] o_arg0,
    output logic [7:0] o_arg1,
    output logic       o_cmd_v,
    output logic       o_err
);
    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {GROUND, ESC, CSI_P0, CSI_P1, CSI_IGN} state_t;

    state_t        state;
    state_t        cur;
    logic          timed_out;
    logic          ign_args;
    logic          pres0, pres1;
    logic [7:0]    arg0, arg1;
    logic [CW-1:0] tcnt;

    function automatic logic [7:0] acc(input logic [7:0] a, input logic [7:0] ch);
        logic [11:0] t;
        t = 12'(a) * 12'd10 + 12'(ch - 8'h30);
        return (t > 12'd255) ? 8'd255 : t[7:0];
    endfunction

    function automatic logic is_fmt(input logic [7:0] b);
        return (b == 8'h08) || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
    endfunction

    function automatic logic [7:0] one_if_zero(input logic p, input logic [7:0] a);
        return (!p || a == 8'd0) ? 8'd1 : a;
    endfunction

    // A timeout aborts first, so a byte on the same edge is parsed from GROUND.
    always_comb begin
        timed_out = (state != GROUND) && (tcnt == TO_LAST);
        cur = timed_out ? GROUND : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= GROUND;
            ign_args <= 1'b0;
            pres0    <= 1'b0;
            pres1    <= 1'b0;
            arg0     <= 8'd0;
            arg1     <= 8'd0;
            tcnt     <= '0;
            o_char   <= 8'd0;
            o_char_v <= 1'b0;
            o_cmd    <= 4'd0;
            o_arg0   <= 8'd0;
            o_arg1   <= 8'd0;
            o_cmd_v  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_char_v <= 1'b0;
            o_cmd_v  <= 1'b0;
            o_err    <= timed_out;
            state    <= cur;
            tcnt     <= (cur == GROUND || i_byte_v) ? '0 : tcnt + CW'(1);

            if (i_byte_v) begin
                if (cur == GROUND) begin
                    if ((i_byte >= 8'h20 && i_byte <= 8'h7E) || is_fmt(i_byte)) begin
                        o_char   <= i_byte;
                        o_char_v <= 1'b1;
                    end else if (i_byte == 8'h1B) begin
                        state <= ESC;
                    end
                end else if (i_byte < 8'h20) begin
                    if (is_fmt(i_byte)) begin
                        o_char   <= i_byte;
                        o_char_v <= 1'b1;
                    end else if (i_byte == 8'h18 || i_byte == 8'h1A) begin
                        o_err <= 1'b1;
                        state <= GROUND;
                    end else if (i_byte == 8'h1B) begin
                        state    <= ESC;
                        arg0     <= 8'd0;
                        arg1     <= 8'd0;
                        pres0    <= 1'b0;
                        pres1    <= 1'b0;
                        ign_args <= 1'b0;
                    end
                end else if (cur == ESC) begin
                    if (i_byte == 8'h5B) begin
                        state    <= CSI_P0;
                        arg0     <= 8'd0;
                        arg1     <= 8'd0;
                        pres0    <= 1'b0;
                        pres1    <= 1'b0;
                        ign_args <= 1'b0;
                    end else if (i_byte == 8'h63) begin
                        o_cmd   <= 4'd8;
                        o_arg0  <= 8'd0;
                        o_arg1  <= 8'd0;
                        o_cmd_v <= 1'b1;
                        state   <= GROUND;
                    end else begin
                        o_err <= 1'b1;
                        state <= GROUND;
                    end
                end else if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
                    if (cur == CSI_P0) begin
                        arg0  <= acc(arg0, i_byte);
                        pres0 <= 1'b1;
                    end else if (cur == CSI_P1) begin
                        arg1  <= acc(arg1, i_byte);
                        pres1 <= 1'b1;
                    end
                end else if (i_byte == 8'h3B) begin
                    if (cur == CSI_P0) begin
                        state <= CSI_P1;
                    end else if (cur == CSI_P1) begin
                        state    <= CSI_IGN;
                        ign_args <= 1'b1;
                    end
                end else if (i_byte <= 8'h3F) begin
                    // Private markers and intermediates make the sequence unsupported.
                    state    <= CSI_IGN;
                    ign_args <= 1'b0;
                end else if (i_byte <= 8'h7E) begin
                    state <= GROUND;
                    if (cur == CSI_IGN && !ign_args) begin
                        o_err <= 1'b1;
                    end else begin
                        case (i_byte)
                            8'h41, 8'h42, 8'h43, 8'h44: begin
                                o_cmd   <= 4'(i_byte - 8'h40);
                                o_arg0  <= one_if_zero(pres0, arg0);
                                o_arg1  <= 8'd0;
                                o_cmd_v <= 1'b1;
                            end
                            8'h48, 8'h66: begin
                                o_cmd   <= 4'd5;
                                o_arg0  <= one_if_zero(pres0, arg0);
                                o_arg1  <= one_if_zero(pres1, arg1);
                                o_cmd_v <= 1'b1;
                            end
                            8'h4A, 8'h4B: begin
                                o_cmd   <= (i_byte == 8'h4A) ? 4'd6 : 4'd7;
                                o_arg0  <= pres0 ? arg0 : 8'd0;
                                o_arg1  <= 8'd0;
                                o_cmd_v <= 1'b1;
                            end
                            default: o_err <= 1'b1;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ansi_parser.sv
// tb/tb_ansi_parser.sv - directed scoreboard bench for ansi_parser
module tb_ansi_parser;
    logic       clk;
    logic       rst;
    logic [7:0] i_byte;
    logic       i_byte_v;
    logic [7:0] o_char;
    logic       o_char_v;
    logic [3:0] o_cmd;
    logic [7:0] o_arg0;
    logic [7:0] o_arg1;
    logic       o_cmd_v;
    logic       o_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    ansi_parser #(.TIMEOUT_CLKS(50)) dut (
        .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v),
        .o_char(o_char), .o_char_v(o_char_v), .o_cmd(o_cmd),
        .o_arg0(o_arg0), .o_arg1(o_arg1), .o_cmd_v(o_cmd_v), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ev_char(input logic [7:0] c);
        return {2'd1, 4'd0, 8'd0, 8'd0, 2'd0, c};
    endfunction

    function automatic logic [31:0] ev_cmd(input logic [3:0] c, input logic [7:0] a0, input logic [7:0] a1);
        return {2'd2, c, a0, a1, 10'd0};
    endfunction

    function automatic logic [31:0] ev_err();
        return {2'd3, 30'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic match(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk(tag, obs, e);
    endtask

    task automatic observe();
        if (o_err) match("err", ev_err());
        if (o_char_v) match("char", ev_char(o_char));
        if (o_cmd_v) match("cmd", ev_cmd(o_cmd, o_arg0, o_arg1));
        if (o_char_v || o_cmd_v) chk("char_cmd_exclusive", 32'(o_char_v & o_cmd_v), 32'd0);
        chk("pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        i_byte   = b;
        i_byte_v = v;
        @(negedge clk);
        i_byte_v = 1'b0;
        observe();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_char"}, 32'(o_char), 32'd0);
        chk({tag, "_valids"}, {29'd0, o_char_v, o_cmd_v, o_err}, 32'd0);
        chk({tag, "_cmd"}, {12'd0, o_cmd, o_arg0, o_arg1}, 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        i_byte   = 8'h00;
        i_byte_v = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        exp_q.push_back(ev_char(8'h48)); step(1'b1, 8'h48);
        exp_q.push_back(ev_char(8'h69)); step(1'b1, 8'h69);
        exp_q.push_back(ev_char(8'h0D)); step(1'b1, 8'h0D);
        exp_q.push_back(ev_char(8'h0A)); step(1'b1, 8'h0A);
        step(1'b1, 8'h07);

        send_str("\033[12;40"); exp_q.push_back(ev_cmd(4'd5, 8'd12, 8'd40)); step(1'b1, "H");
        send_str("\033[");      exp_q.push_back(ev_cmd(4'd5, 8'd1, 8'd1));   step(1'b1, "H");
        send_str("\033[");      exp_q.push_back(ev_cmd(4'd3, 8'd1, 8'd0));   step(1'b1, "C");
        send_str("\033[0");     exp_q.push_back(ev_cmd(4'd3, 8'd1, 8'd0));   step(1'b1, "C");
        send_str("\033[9999");  exp_q.push_back(ev_cmd(4'd1, 8'd255, 8'd0)); step(1'b1, "A");
        send_str("\033[");      exp_q.push_back(ev_cmd(4'd7, 8'd0, 8'd0));   step(1'b1, "K");
        send_str("\033[2");     exp_q.push_back(ev_cmd(4'd6, 8'd2, 8'd0));   step(1'b1, "J");
        send_str("\033");       exp_q.push_back(ev_cmd(4'd8, 8'd0, 8'd0));   step(1'b1, "c");
        exp_q.push_back(ev_char("x")); step(1'b1, "x");
        chk("cmd_hold", {12'd0, o_cmd, o_arg0, o_arg1}, {12'd0, 4'd8, 8'd0, 8'd0});

        send_str("\033[10");
        exp_q.push_back(ev_char(8'h0A));               step(1'b1, 8'h0A);
        exp_q.push_back(ev_cmd(4'd2, 8'd10, 8'd0));    step(1'b1, "B");
        send_str("\033[5");  exp_q.push_back(ev_err()); step(1'b1, 8'h18);
        send_str("\033[3\033[4"); exp_q.push_back(ev_cmd(4'd4, 8'd4, 8'd0)); step(1'b1, "D");

        send_str("\033[?25");   exp_q.push_back(ev_err()); step(1'b1, "h");
        send_str("\033[1;2;3"); exp_q.push_back(ev_cmd(4'd5, 8'd1, 8'd2)); step(1'b1, "H");
        send_str("\033");       exp_q.push_back(ev_err()); step(1'b1, "x");

        send_str("\033[7");
        repeat (49) step(1'b0, 8'h00);
        exp_q.push_back(ev_err());    step(1'b0, 8'h00);
        exp_q.push_back(ev_char("A")); step(1'b1, "A");

        send_str("\033[7");
        rst = 1'b0;
        step(1'b0, 8'h00);
        check_zero("mid_reset");
        rst = 1'b1;
        exp_q.push_back(ev_char("B")); step(1'b1, "B");
        repeat (60) step(1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
